// File: rtl/vga_pixel_fetch_if.sv
// Frame-buffer read FIFO port of vga_pixel_fetch.
//   fifo_empty    FIFO has no data to pop
//   fifo_rd_data  popped pixel {r,g,b}, valid RD_LAT cycles after fifo_rd_en
//   fifo_rd_en    pop strobe
// master: the pixel fetch stage (consumer); slave: the FIFO.
interface vga_pixel_fetch_if;
    logic        fifo_empty;
    logic [23:0] fifo_rd_data;
    logic        fifo_rd_en;

    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_rd_data
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_rd_data
    );
endinterface

// File: rtl/vga_pixel_fetch.sv
// Pixel fetch stage behind the 1080p VGA timing generator.
// Pops RGB pixels from the frame-buffer read FIFO while the timing generator
// asserts DE, re-aligns syncs/DE with the returned data, substitutes FILL_RGB
// on underflow, pulses frame_req once per frame, and keeps integrity stats.
// Ports:
//   vga_clk, rst_n          pixel clock, async active-low reset
//   tim_h_sync/v_sync/de    raw timing from the generator
//   fifo                    read FIFO port (master side)
//   frame_req               1-cycle DMA restart pulse after each v_sync rise
//   stat_clr                synchronous clear of the statistics below
//   h_sync, v_sync, de      timing delayed by RD_LAT+1 cycles
//   r, g, b                 registered pixel colour, aligned to de
//   underflow_cnt           saturating count of underflow pixels (ACTIVE only)
//   line_err                sticky: an active line was not H_ACT pixels long
//   frame_err               sticky: a frame did not have V_ACT active lines
module vga_pixel_fetch #(
    parameter int          H_ACT    = 1920,
    parameter int          V_ACT    = 1080,
    parameter int          RD_LAT   = 1,
    parameter logic [23:0] FILL_RGB = 24'h0
) (
    input  logic                    vga_clk,
    input  logic                    rst_n,
    input  logic                    tim_h_sync,
    input  logic                    tim_v_sync,
    input  logic                    tim_de,
    vga_pixel_fetch_if.master       fifo,
    output logic                    frame_req,
    input  logic                    stat_clr,
    output logic                    h_sync,
    output logic                    v_sync,
    output logic                    de,
    output logic [7:0]              r,
    output logic [7:0]              g,
    output logic [7:0]              b,
    output logic [15:0]             underflow_cnt,
    output logic                    line_err,
    output logic                    frame_err
);

    localparam int         L       = RD_LAT + 1;
    localparam logic [11:0] H_ACT_C = 12'(H_ACT);
    localparam logic [11:0] V_ACT_C = 12'(V_ACT);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [0:0]        state;
    logic              vs_d;
    logic              de_d;
    logic [L-1:0]      h_pipe;
    logic [L-1:0]      v_pipe;
    logic [L-1:0]      de_pipe;
    logic [RD_LAT-1:0] vld_pipe;
    logic [23:0]       rgb_q;
    logic [11:0]       pix_cnt;
    logic [11:0]       line_cnt;

    logic vs_rise;
    logic de_rise;
    logic de_fall;
    logic rd_en;
    logic uf_inc;
    logic line_ev;
    logic frame_ev;

    always_comb begin
        vs_rise  = tim_v_sync & ~vs_d;
        de_rise  = tim_de & ~de_d;
        de_fall  = ~tim_de & de_d;
        rd_en    = tim_de & ~fifo.fifo_empty & (state == ACTIVE);
        // IDLE fill pixels are expected, so only ACTIVE underflow is counted.
        uf_inc   = tim_de & fifo.fifo_empty & (state == ACTIVE);
        line_ev  = de_fall & (pix_cnt != H_ACT_C);
        // The partial frame before the first v_sync after reset is seen in IDLE.
        frame_ev = vs_rise & (state == ACTIVE) & (line_cnt != V_ACT_C);
    end

    assign fifo.fifo_rd_en = rd_en;
    assign h_sync          = h_pipe[L-1];
    assign v_sync          = v_pipe[L-1];
    assign de              = de_pipe[L-1];
    assign {r, g, b}       = rgb_q;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            vs_d          <= 1'b0;
            de_d          <= 1'b0;
            frame_req     <= 1'b0;
            h_pipe        <= '0;
            v_pipe        <= '0;
            de_pipe       <= '0;
            vld_pipe      <= '0;
            rgb_q         <= '0;
            pix_cnt       <= '0;
            line_cnt      <= '0;
            underflow_cnt <= '0;
            line_err      <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            vs_d      <= tim_v_sync;
            de_d      <= tim_de;
            frame_req <= vs_rise;
            if (vs_rise)
                state <= ACTIVE;

            h_pipe[0]   <= tim_h_sync;
            v_pipe[0]   <= tim_v_sync;
            de_pipe[0]  <= tim_de;
            for (int unsigned i = 1; i < L; i++) begin
                h_pipe[i]  <= h_pipe[i-1];
                v_pipe[i]  <= v_pipe[i-1];
                de_pipe[i] <= de_pipe[i-1];
            end
            vld_pipe[0] <= rd_en;
            for (int unsigned i = 1; i < RD_LAT; i++)
                vld_pipe[i] <= vld_pipe[i-1];

            // Stage RD_LAT-1 is the cycle where popped data is on the bus;
            // registering it lands the colour on the same cycle as de.
            if (!de_pipe[RD_LAT-1])
                rgb_q <= '0;
            else if (vld_pipe[RD_LAT-1])
                rgb_q <= fifo.fifo_rd_data;
            else
                rgb_q <= FILL_RGB;

            if (de_rise)
                pix_cnt <= 12'd1;
            else if (tim_de && pix_cnt != '1)
                pix_cnt <= pix_cnt + 12'd1;

            if (vs_rise)
                line_cnt <= '0;
            else if (de_fall && line_cnt != '1)
                line_cnt <= line_cnt + 12'd1;

            // A new event in the same cycle as stat_clr survives the clear.
            if (uf_inc) begin
                if (stat_clr)
                    underflow_cnt <= 16'd1;
                else if (underflow_cnt != '1)
                    underflow_cnt <= underflow_cnt + 16'd1;
            end else if (stat_clr) begin
                underflow_cnt <= '0;
            end
            line_err  <= line_ev  | (line_err  & ~stat_clr);
            frame_err <= frame_ev | (frame_err & ~stat_clr);
        end
    end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Self-checking bench for vga_pixel_fetch with a reduced raster
// (16 pixels x 4 lines) so whole frames fit in a short run.
module tb_vga_pixel_fetch;

    localparam int          H    = 16;
    localparam int          V    = 4;
    localparam int          LAT  = 1;
    localparam int          L    = LAT + 1;
    localparam logic [23:0] FILL = 24'hA55AC3;

    logic        vga_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        t_h, t_v, t_de, t_clr;
    logic        frame_req, h_sync, v_sync, de, line_err, frame_err;
    logic [7:0]  r, g, b;
    logic [15:0] underflow_cnt;

    vga_pixel_fetch_if ifc ();

    vga_pixel_fetch #(
        .H_ACT(H), .V_ACT(V), .RD_LAT(LAT), .FILL_RGB(FILL)
    ) dut (
        .vga_clk(vga_clk), .rst_n(rst_n),
        .tim_h_sync(t_h), .tim_v_sync(t_v), .tim_de(t_de),
        .fifo(ifc), .frame_req(frame_req), .stat_clr(t_clr),
        .h_sync(h_sync), .v_sync(v_sync), .de(de),
        .r(r), .g(g), .b(b),
        .underflow_cnt(underflow_cnt), .line_err(line_err), .frame_err(frame_err)
    );

    always #5 vga_clk = ~vga_clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: expected output history per input cycle.
    logic [26:0] hist [8];
    int          cyc  = 8;
    bit          m_active, m_pv, m_pde, m_lerr, m_ferr, m_fr;
    int          run, lines, mpop, spop;
    logic [15:0] m_uf;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: evaluate the model on the applied inputs, check the pop
    // strobe, clock, answer a pop like a FIFO, then check registered outputs.
    task automatic step();
        logic [26:0] ent;
        bit pop, uf, vr, rise, fall, lev, fev, rd_seen;
        #1;
        pop = 0;
        if (!rst_n) begin
            m_active = 0; m_pv = 0; m_pde = 0; run = 0; lines = 0;
            m_uf = '0; m_lerr = 0; m_ferr = 0; m_fr = 0;
            ent = '0;
        end else begin
            vr   = t_v & ~m_pv;
            rise = t_de & ~m_pde;
            fall = ~t_de & m_pde;
            pop  = t_de & ~ifc.fifo_empty & m_active;
            uf   = t_de & ifc.fifo_empty & m_active;
            ent  = {t_h, t_v, t_de, !t_de ? 24'h0 : (pop ? 24'(mpop) : FILL)};
            if (pop) mpop++;
            if (rise) run = 1;
            else if (t_de) run++;
            lev = fall && (run != H);
            fev = 0;
            if (vr) begin
                fev   = m_active && (lines != V);
                lines = 0;
            end else if (fall) begin
                lines++;
            end
            m_lerr = t_clr ? lev : (m_lerr | lev);
            m_ferr = t_clr ? fev : (m_ferr | fev);
            if (uf) m_uf = t_clr ? 16'd1 : ((m_uf == 16'hFFFF) ? m_uf : m_uf + 16'd1);
            else if (t_clr) m_uf = '0;
            m_fr = vr;
            if (vr) m_active = 1;
            m_pv  = t_v;
            m_pde = t_de;
        end
        chk("fifo_rd_en", 24'(ifc.fifo_rd_en), 24'(pop));
        rd_seen = ifc.fifo_rd_en;
        hist[cyc % 8] = ent;
        @(posedge vga_clk);
        cyc++;
        #1;
        if (rd_seen) begin
            ifc.fifo_rd_data = 24'(spop);
            spop++;
        end else begin
            ifc.fifo_rd_data = 24'($urandom);
        end
        ent = rst_n ? hist[(cyc - L) % 8] : '0;
        chk("h_sync", 24'(h_sync), 24'(ent[26]));
        chk("v_sync", 24'(v_sync), 24'(ent[25]));
        chk("de", 24'(de), 24'(ent[24]));
        chk("rgb", {r, g, b}, ent[23:0]);
        chk("frame_req", 24'(frame_req), 24'(m_fr));
        chk("underflow_cnt", 24'(underflow_cnt), 24'(m_uf));
        chk("line_err", 24'(line_err), 24'(m_lerr));
        chk("frame_err", 24'(frame_err), 24'(m_ferr));
        @(negedge vga_clk);
    endtask

    task automatic tick(input bit h, input bit v, input bit d, input bit emp, input bit clr);
        t_h = h; t_v = v; t_de = d; ifc.fifo_empty = emp; t_clr = clr;
        step();
    endtask

    // Blanking with an h_sync pulse, npix DE cycles, two trailing blanks.
    // Pixels e0..e0+elen-1 see an empty FIFO; rnd sprinkles random empties
    // and stat_clr; clr_fall raises stat_clr on the DE falling-edge cycle.
    task automatic line(input int npix, input bit vs, input int e0, input int elen,
                        input bit clr_fall, input bit rnd);
        for (int i = 0; i < 4; i++) tick(i == 1 || i == 2, vs, 0, 0, 0);
        for (int i = 0; i < npix; i++)
            tick(0, vs, 1,
                 (i >= e0 && i < e0 + elen) || (rnd && $urandom_range(0, 7) == 0),
                 rnd && $urandom_range(0, 15) == 0);
        tick(0, vs, 0, 0, clr_fall);
        tick(0, vs, 0, 0, 0);
    endtask

    task automatic frame(input int nlines, input int short_idx, input int emp_idx, input bit rnd);
        line(0, 1, 0, 0, 0, 0);
        line(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < nlines; k++)
            line((k == short_idx) ? H - 1 : H, 0,
                 (k == emp_idx) ? 3 : 0, (k == emp_idx) ? 10 : 0, 0, rnd);
    endtask

    initial begin
        t_h = 0; t_v = 0; t_de = 0; t_clr = 0;
        ifc.fifo_empty   = 1'b0;
        ifc.fifo_rd_data = '0;
        mpop = 0; spop = 0;
        for (int i = 0; i < 8; i++) hist[i] = '0;

        @(negedge vga_clk);
        for (int i = 0; i < 3; i++) tick(0, 0, i == 2, 0, 0);
        rst_n = 1'b1;

        // Raster before the first v_sync: fill pixels, no pops.
        line(H, 0, 0, 0, 0, 0);
        line(H, 0, 0, 0, 0, 0);
        frame(V, -1, -1, 0);
        frame(V, -1, -1, 0);
        chk("clean_frames_uf", 24'(underflow_cnt), 24'd0);
        chk("clean_frames_err", {22'd0, line_err, frame_err}, 24'd0);

        frame(V, -1, 1, 0);
        chk("uf_after_gap", 24'(underflow_cnt), 24'd10);

        frame(V, 2, -1, 0);
        chk("line_err_short", 24'(line_err), 24'd1);
        tick(0, 0, 0, 0, 1);
        chk("line_err_clr", 24'(line_err), 24'd0);
        line(H - 1, 0, 0, 0, 1, 0);
        chk("line_err_coinc", 24'(line_err), 24'd1);
        frame(V, -1, -1, 0);
        chk("frame_err_5lines", 24'(frame_err), 24'd1);
        tick(0, 0, 0, 0, 1);

        frame(V, -1, -1, 1);
        frame(V, -1, -1, 1);

        // Reset in the middle of an active line.
        tick(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) tick(0, 0, 1, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_outs",
            {10'd0, h_sync, v_sync, de, frame_req, line_err, frame_err, r}, 24'd0);
        chk("rst_async_rgb_uf", {g, underflow_cnt}, 24'd0);
        chk("rst_async_rd_en", 24'(ifc.fifo_rd_en), 24'd0);
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 1, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick(0, 0, 1, 0, 0);
        tick(0, 0, 0, 0, 0);
        line(H, 0, 0, 0, 0, 0);
        line(H, 0, 0, 0, 0, 0);
        frame(V, -1, -1, 0);
        chk("frame_err_partial", 24'(frame_err), 24'd0);

        // Sustained underflow up to and past saturation.
        tick(0, 0, 0, 0, 1);
        for (int i = 0; i < 65540; i++) tick(0, 0, 1, 1, 0);
        tick(0, 0, 0, 0, 0);
        chk("uf_saturate", 24'(underflow_cnt), 24'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
